llr_buffer: RTL

LLR_BUFFER -- requirements
Module: llr_buffer

---
 rtl/llr_pkg.sv | 10 +
 rtl/llrb_mem.sv | 23 ++
 rtl/llr_buffer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/llr_pkg.sv
// Shared widths and the replay FSM state type for the link-level-retry buffer.
package llr_pkg;
  localparam int FLIT_W = 528;
  localparam int PTR_W  = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REPLAY = 1'b1
  } llr_state_t;
endpackage

// File: rtl/llrb_mem.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read port.
module llrb_mem #(
  parameter int W  = 528,
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [0:(1<<AW)-1];
  logic [W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/llr_buffer.sv
// Link-level-retry buffer: holds unacknowledged flits in a circular store of
// run-time capacity and replays them from the peer's expected sequence.
module llr_buffer #(
  parameter int FLIT_W = llr_pkg::FLIT_W,
  parameter int PTR_W  = llr_pkg::PTR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [FLIT_W-1:0] i_flit_w_crc,
  input  logic [PTR_W-1:0]  i_llr_wrap_value,
  input  logic              i_ack_valid,
  input  logic [PTR_W:0]    i_ack_num,
  input  logic              i_replay_start,
  input  logic [PTR_W-1:0]  i_replay_eseq,
  input  logic              i_rd_en,
  output logic [FLIT_W-1:0] o_flit,
  output logic              o_flit_valid,
  output logic              o_replay_done,
  output logic [PTR_W-1:0]  o_wr_ptr,
  output logic [PTR_W:0]    o_num_used,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_wr_overflow_err,
  output logic              o_ack_err
);
  import llr_pkg::*;

  localparam logic [PTR_W-1:0] ONE_P = 1;
  localparam logic [PTR_W:0]   ONE_U = 1;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p,
                                                input logic [PTR_W-1:0] wrap);
    return (p == wrap) ? '0 : p + ONE_P;
  endfunction

  // p < cap and n <= cap, so the sum never exceeds PTR_W+1 bits
  function automatic logic [PTR_W-1:0] add_ptr(input logic [PTR_W-1:0] p,
                                                input logic [PTR_W:0]   n,
                                                input logic [PTR_W:0]   cap);
    logic [PTR_W:0] s;
    s = {1'b0, p} + n;
    if (s >= cap) s = s - cap;
    return s[PTR_W-1:0];
  endfunction

  llr_state_t       r_state, w_state_d;
  logic [PTR_W:0]   r_cap, r_used;
  logic [PTR_W-1:0] r_wrap, r_wr_ptr, r_tail_ptr, r_rd_ptr, r_end_ptr;
  logic             r_flit_vld, r_done, r_ovf, r_ack_err;

  logic             w_full, w_wr_acc, w_ack_bad, w_rd_req, w_load, w_done_d;
  logic [PTR_W-1:0] w_wr_next, w_rd_next;
  logic [FLIT_W-1:0] w_rdata;

  assign w_full    = (r_used == r_cap);
  assign w_wr_acc  = i_wr_en & ~w_full;
  assign w_wr_next = w_wr_acc ? inc_ptr(r_wr_ptr, r_wrap) : r_wr_ptr;
  assign w_ack_bad = i_ack_valid & (i_ack_num > r_used);
  assign w_rd_next = inc_ptr(r_rd_ptr, r_wrap);

  always_comb begin
    w_state_d = r_state;
    w_rd_req  = 1'b0;
    w_load    = 1'b0;
    w_done_d  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_replay_start) begin
          w_load = 1'b1;
          if (i_replay_eseq == r_wr_ptr) w_done_d  = 1'b1;
          else                           w_state_d = ST_REPLAY;
        end
      end
      ST_REPLAY: begin
        if (i_rd_en) begin
          w_rd_req = 1'b1;
          if (w_rd_next == r_end_ptr) begin
            w_done_d  = 1'b1;
            w_state_d = ST_IDLE;
          end
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cap      <= {1'b0, i_llr_wrap_value} + ONE_U;
      r_wrap     <= i_llr_wrap_value;
      r_state    <= ST_IDLE;
      r_used     <= '0;
      r_wr_ptr   <= '0;
      r_tail_ptr <= '0;
      r_rd_ptr   <= '0;
      r_end_ptr  <= '0;
      r_flit_vld <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_ack_err  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_wr_ptr   <= w_wr_next;
      r_flit_vld <= w_rd_req;
      r_done     <= w_done_d;
      r_ovf      <= i_wr_en & w_full;
      r_ack_err  <= w_ack_bad;
      // over-ack: resynchronise to an empty buffer at the new write point
      if (w_ack_bad) begin
        r_used     <= '0;
        r_tail_ptr <= w_wr_next;
      end else begin
        r_used <= r_used + (PTR_W+1)'(w_wr_acc) - (i_ack_valid ? i_ack_num : '0);
        if (i_ack_valid) r_tail_ptr <= add_ptr(r_tail_ptr, i_ack_num, r_cap);
      end
      if (w_load) begin
        r_rd_ptr  <= i_replay_eseq;
        r_end_ptr <= r_wr_ptr;
      end else if (w_rd_req) begin
        r_rd_ptr <= w_rd_next;
      end
    end
  end

  llrb_mem #(.W(FLIT_W), .AW(PTR_W)) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_flit_w_crc),
    .i_re    (w_rd_req),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign o_flit            = r_flit_vld ? w_rdata : '0;
  assign o_flit_valid      = r_flit_vld;
  assign o_replay_done     = r_done;
  assign o_wr_ptr          = r_wr_ptr;
  assign o_num_used        = r_used;
  assign o_full            = w_full;
  assign o_empty           = (r_used == '0);
  assign o_wr_overflow_err = r_ovf;
  assign o_ack_err         = r_ack_err;
endmodule
